// File: rtl/fetch_queue.sv
// Fetch queue: issues PC reads to a 1-cycle synchronous imem and buffers {instr, pc} for decode.
// Define FETCH_QUEUE_PERF_EN to add the perf_stall_cnt / perf_flush_cnt counter outputs.
module fetch_queue #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_VECT = 32'h0000_0000,
  parameter int          DATA_W     = 32,
  // Address width follows the PC reset vector width
  localparam int         AW         = $bits(RESET_VECT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     pc,
  input  logic              pc_ena,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              imem_en,
  output logic [AW-1:0]     imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [AW-1:0]     out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]     pc_mem    [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              vld_p1;
  logic [AW-1:0]     tag_p1;
  logic              pop;
  logic              wr_en;
  logic              issue;
  logic [CW:0]       occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Occupancy after this edge if we did not issue; an issue is only safe below DEPTH.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, vld_p1} - {{CW{1'b0}}, pop};
  assign pc_stall = ~redirect & (occ >= (CW + 1)'(DEPTH));

  // p0: issue read to imem
  assign issue     = pc_ena & ~pc_stall & ~redirect & ~reset;
  assign imem_en   = issue;
  assign imem_addr = pc;

  // p1: response returns, captured at the tail unless flushed
  assign wr_en = vld_p1 & ~redirect;

  // Storage is not reset, so outputs are gated to stay zero while empty.
  assign out_instr = out_valid ? instr_mem[head] : '0;
  assign out_pc    = out_valid ? pc_mem[head]    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      vld_p1 <= 1'b0;
    end else if (redirect) begin
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (wr_en) tail <= ptr_inc(tail);
      if (pop)   head <= ptr_inc(head);
      unique case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_p1 <= pc;
    if (wr_en) begin
      instr_mem[tail] <= imem_rdata;
      pc_mem[tail]    <= tag_p1;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Flush count includes buffered entries plus a response still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'(count) + 32'(vld_p1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=2 instance (u_a) and DEPTH=4 instance (u_b) share stimulus.
// Perf counter checks are compiled in with FETCH_QUEUE_PERF_EN.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pc_ena, redirect, out_ready;
  logic [31:0] pc;

  logic        a_stall, a_en, a_valid;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc;
  logic        b_stall, b_en, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] a_pstall, a_pflush, b_pstall, b_pflush;
`endif

  fetch_queue #(.DEPTH(2), .RESET_VECT(32'h0)) u_a (
    .clk(clk), .reset(reset), .pc(pc), .pc_ena(pc_ena), .redirect(redirect),
    .pc_stall(a_stall), .imem_en(a_en), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .out_valid(a_valid), .out_ready(out_ready), .out_instr(a_instr), .out_pc(a_pc)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
`endif
  );

  fetch_queue #(.DEPTH(4), .RESET_VECT(32'h0)) u_b (
    .clk(clk), .reset(reset), .pc(pc), .pc_ena(pc_ena), .redirect(redirect),
    .pc_stall(b_stall), .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_instr(b_instr), .out_pc(b_pc)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
`endif
  );

  // Synchronous imem model: data = address + 0x100, one cycle after the read
  always @(posedge clk) begin
    if (a_en) a_rdata <= a_addr + 32'h100;
    if (b_en) b_rdata <= b_addr + 32'h100;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy invariants on both instances
  always @(negedge clk) begin
    if (!reset) begin
      check("a_count_le_depth", 32'(u_a.count <= 2), 32'd1);
      check("a_no_full_write", 32'(u_a.wr_en && (u_a.count == 2) && !u_a.pop), 32'd0);
      check("b_count_le_depth", 32'(u_b.count <= 4), 32'd1);
      check("b_no_full_write", 32'(u_b.wr_en && (u_b.count == 4) && !u_b.pop), 32'd0);
    end
  end

  initial begin
    reset = 1'b1; pc_ena = 1'b1; redirect = 1'b0; out_ready = 1'b1; pc = 32'h0;
    tick();
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_imem_en", a_en, 0);
    check("rst_stall", a_stall, 0);
    check("rst_instr", a_instr, 0);
    check("rst_pc", a_pc, 0);
    check("rst_count", u_a.count, 0);
`ifdef FETCH_QUEUE_PERF_EN
    check("rst_pstall", a_pstall, 0);
    check("rst_pflush", a_pflush, 0);
`endif

    // Streaming 0,4,8 with decode always ready
    reset = 1'b0; pc = 32'h0; #1;
    check("s1_c0_en", a_en, 1);
    check("s1_c0_addr", a_addr, 32'h0);
    check("s1_c0_valid", a_valid, 0);
    check("s1_c0_stall", a_stall, 0);
    tick(); pc = 32'h4; #1;
    check("s1_c1_en", a_en, 1);
    check("s1_c1_valid", a_valid, 0);
    check("s1_c1_stall", a_stall, 0);
    tick(); pc = 32'h8; #1;
    check("s1_c2_valid", a_valid, 1);
    check("s1_c2_pc", a_pc, 32'h0);
    check("s1_c2_instr", a_instr, 32'h100);
    check("s1_c2_stall", a_stall, 0);
    check("s1_c2_en", a_en, 1);
    tick(); pc_ena = 1'b0; #1;
    check("s1_c3_valid", a_valid, 1);
    check("s1_c3_pc", a_pc, 32'h4);
    check("s1_c3_instr", a_instr, 32'h104);
    check("s1_c3_stall", a_stall, 0);
    tick(); #1;
    check("s1_c4_pc", a_pc, 32'h8);
    check("s1_c4_instr", a_instr, 32'h108);
    tick(); #1;
    check("s1_c5_valid", a_valid, 0);

    // DEPTH=2 backpressure
    reset = 1'b1; out_ready = 1'b0; pc_ena = 1'b1; pc = 32'h0;
    tick(); reset = 1'b0; #1;
    check("s2_c0_en", a_en, 1);
    check("s2_c0_stall", a_stall, 0);
    tick(); pc = 32'h4; #1;
    check("s2_c1_en", a_en, 1);
    check("s2_c1_stall", a_stall, 0);
    tick(); pc = 32'h8; #1;
    check("s2_c2_stall", a_stall, 1);
    check("s2_c2_en", a_en, 0);
    tick(); #1;
    check("s2_c3_stall", a_stall, 1);
    check("s2_c3_count", u_a.count, 2);
    check("s2_c3_valid", a_valid, 1);
    check("s2_c3_pc", a_pc, 32'h0);
    tick(); #1;
    check("s2_c4_stall", a_stall, 1);
    check("s2_c4_pc_held", a_pc, 32'h0);
    out_ready = 1'b1; #1;
    check("s2_c5_stall_drop", a_stall, 0);
    check("s2_c5_en", a_en, 1);
    check("s2_c5_pc", a_pc, 32'h0);
    check("s2_c5_instr", a_instr, 32'h100);
    tick(); pc_ena = 1'b0; #1;
    check("s2_c6_pc", a_pc, 32'h4);
    check("s2_c6_instr", a_instr, 32'h104);
    tick(); #1;
    check("s2_c7_pc", a_pc, 32'h8);
    tick(); #1;
    check("s2_c8_valid", a_valid, 0);

    // DEPTH=4: 5 stall cycles, partial drain, then flush 2 buffered + 1 inflight
    reset = 1'b1; out_ready = 1'b0; pc_ena = 1'b1; pc = 32'h8;
    tick(); reset = 1'b0; #1;
    check("s3_c0_en", b_en, 1);
    check("s3_c0_addr", b_addr, 32'h8);
    tick(); pc = 32'hC;
    tick(); pc = 32'h10;
    tick(); pc = 32'h14; #1;
    check("s3_c3_stall", b_stall, 0);
    check("s3_c3_en", b_en, 1);
    tick(); pc = 32'h18; #1;
    check("s3_c4_stall", b_stall, 1);
    check("s3_c4_en", b_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("s3_stall_hold", b_stall, 1);
    end
    tick(); out_ready = 1'b1; pc_ena = 1'b0; #1;
    check("s3_c9_stall", b_stall, 0);
    check("s3_c9_pc", b_pc, 32'h8);
    check("s3_c9_instr", b_instr, 32'h108);
    tick(); #1;
    check("s3_c10_pc", b_pc, 32'hC);
    tick(); out_ready = 1'b0; pc_ena = 1'b1; #1;
    check("s3_c11_en", b_en, 1);
    check("s3_c11_addr", b_addr, 32'h18);
    check("s3_c11_head", b_pc, 32'h10);
    check("s3_c11_count", u_b.count, 2);
    tick(); redirect = 1'b1; pc = 32'h1C; #1;
    check("s3_redir_stall", b_stall, 0);
    check("s3_redir_en", b_en, 0);
    check("s3_redir_count", u_b.count, 2);
    check("s3_redir_inflight", u_b.vld_p1, 1);
    tick(); redirect = 1'b0; pc = 32'h200; #1;
    check("s3_post_valid", b_valid, 0);
    check("s3_post_count", u_b.count, 0);
    check("s3_vect_en", b_en, 1);
    check("s3_vect_addr", b_addr, 32'h200);
`ifdef FETCH_QUEUE_PERF_EN
    check("s3_perf_stall", b_pstall, 32'd5);
    check("s3_perf_flush", b_pflush, 32'd3);
`endif
    tick(); pc_ena = 1'b0; #1;
    check("s3_lat_valid", b_valid, 0);
    tick(); #1;
    check("s3_vect_valid", b_valid, 1);
    check("s3_vect_pc", b_pc, 32'h200);
    check("s3_vect_instr", b_instr, 32'h300);

    // Redirect while decode pops a valid head
    reset = 1'b1; out_ready = 1'b1; pc_ena = 1'b1; pc = 32'h40;
    tick(); reset = 1'b0;
    tick(); pc = 32'h44;
    tick(); redirect = 1'b1; pc = 32'h48; #1;
    check("s4_head_valid", a_valid, 1);
    check("s4_head_pc", a_pc, 32'h40);
    check("s4_stall", a_stall, 0);
    check("s4_en", a_en, 0);
    tick(); redirect = 1'b0; pc_ena = 1'b0; #1;
    check("s4_c3_valid", a_valid, 0);
    check("s4_c3_count", u_a.count, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("s4_no_dup", a_valid, 0);
    end

    // Reset with two buffered and one inflight
    reset = 1'b1; out_ready = 1'b0; pc_ena = 1'b1; pc = 32'h60;
    tick(); reset = 1'b0;
    tick(); pc = 32'h64;
    tick(); pc = 32'h68;
    tick(); reset = 1'b1; pc = 32'h6C; #1;
    check("s5_pre_count", u_b.count, 2);
    check("s5_pre_inflight", u_b.vld_p1, 1);
    check("s5_rst_en", b_en, 0);
    tick(); reset = 1'b0; pc = 32'h300; #1;
    check("s5_valid", b_valid, 0);
    check("s5_en", b_en, 1);
    check("s5_stall", b_stall, 0);
    check("s5_addr", b_addr, 32'h300);
`ifdef FETCH_QUEUE_PERF_EN
    check("s5_perf_flush", b_pflush, 32'd0);
`endif
    tick(); pc_ena = 1'b0; #1;
    check("s5_lat_valid", b_valid, 0);
    tick(); #1;
    check("s5_new_valid", b_valid, 1);
    check("s5_new_pc", b_pc, 32'h300);
    check("s5_new_instr", b_instr, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the program counter interface.
- Takes the current fetch address and enable from the PC register and issues reads to a synchronous instruction memory with one-cycle read latency.
- Tags each returned instruction with its address and buffers it in a small FIFO for decode.
- Drives stall back to the PC when the FIFO would overflow, and flushes all in-flight and buffered fetches when the PC is redirected.

Parameters:
- DEPTH, 2, FIFO entries (instr+pc pairs); legal range 2..8.
- RESET_VECT, 32'h00000000, reserved; must equal the PC reset value. Not used in logic, checked by bench only.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pc  in  32  current fetch address from PC
- pc_ena  in  1  PC output valid; fetch only when high
- redirect  in  1  same signal as PC sel; high = PC loads vect at next edge
- pc_stall  out  1  holds PC (drives PC stall input)
- imem_en  out  1  instruction memory read enable
- imem_addr  out  32  read address, equals pc
- imem_rdata  in  32  read data, valid the cycle after imem_en
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  address of head instruction

Behaviour:
- Reset (sync, priority over all): count=0, inflight=0, FIFO pointers=0. out_valid=0, imem_en=0, pc_stall=0, out_instr/out_pc=0.
- pop = out_valid & out_ready.
- pc_stall = ~redirect & ((count + inflight - pop) >= DEPTH).
  - Combinational; out_ready→pc_stall path is allowed.
  - Forced 0 on redirect so the PC accepts vect; the PC ignores sel while stalled.
- Issue: imem_en = pc_ena & ~pc_stall & ~redirect & ~reset; imem_addr = pc always.
  - On issue, register inflight<=1 and tag<=pc; else inflight<=0.
- Response: cycle after issue with inflight=1 and no redirect, write {imem_rdata, tag} at tail; tail wraps modulo DEPTH.
- Latency: issue at cycle N, FIFO write at edge ending N+1, out_valid high in N+2. No bypass from imem_rdata to outputs.
- Output: out_valid = (count != 0); out_instr/out_pc = head entry.
  - Head is held stable while out_valid & ~out_ready.
  - Pop advances head modulo DEPTH.
- Simultaneous write and pop: count unchanged, both pointers advance.
- Overflow is impossible by the stall rule. Bench asserts count <= DEPTH and no write when count==DEPTH & ~pop.
- Throughput: with DEPTH>=2 and out_ready held high, one issue and one pop per cycle in steady state.
- Redirect (flush), at the edge:
  - count<=0 and head=tail=0.
  - An inflight response arriving that cycle is discarded.
  - inflight<=0 and no issue that cycle.
  - out_valid=0 the following cycle; first fetch at the new vect is issued the cycle after redirect.
- Redirect with empty FIFO and nothing inflight: same actions, no other effect.
- pc_ena low: no issue; buffered entries still drain.
- Reset asserted mid-operation: all entries and the inflight response are dropped at that edge.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: two extra outputs.
  - perf_stall_cnt[31:0]: +1 each cycle pc_stall=1.
  - perf_flush_cnt[31:0]: +1 per entry discarded by redirect, counting buffered entries plus a dropped inflight response.
  - Both wrap at 2^32 and are cleared by reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then pc sequence 0,4,8 with out_ready=1; imem returns pc+32'h100: out_valid first high 2 cycles after first issue; outputs (0,0x100),(4,0x104),(8,0x108) on consecutive cycles; pc_stall never 1.
- out_ready=0 from reset, DEPTH=2: two issues (pc 0,4), then pc_stall=1 and held; count=2. Raise out_ready: pc_stall drops the same cycle; entries pop in order 0 then 4.
- FIFO holds pc 0x10,0x14, one inflight at 0x18; assert redirect one cycle: pc_stall=0 that cycle; next cycle out_valid=0; 0x18 data never appears; next issued address is vect (e.g. 0x200).
- Redirect in the same cycle as out_ready=1 with a valid head: head is considered consumed by decode, FIFO empty afterward, no duplicate output.
- Reset asserted while count=2 and inflight=1: next cycle out_valid=0, imem_en follows pc_ena with pc_stall=0, no stale entry emitted.
- With FETCH_QUEUE_PERF_EN: stall scenario of 5 stall cycles then redirect with 2 buffered + 1 inflight → perf_stall_cnt=5, perf_flush_cnt=3.
